// File: rtl/mp_add_seq.sv
// ---------------------------------------------------------------------------
// mp_add_seq -- multi-precision sequential adder/subtractor.
//
// Adds or subtracts two N-bit operands (N = WIDTH*WORDS) one WIDTH-bit word
// per clock, LSW first. A single 32-bit carry-lookahead adder is shared
// across all words, and a carry register links the words together.
// Subtraction is done as a + ~b + 1. The operand b is inverted when it is
// latched, and the carry register is preset to 1.
//
// Ports:
//   clk   : clock; all state changes on the rising edge
//   rst   : synchronous active-high reset
//   start : request pulse, sampled only while busy=0 (IDLE or DONE)
//   sub   : 0 = a+b, 1 = a-b; sampled with start
//   a, b  : N-bit operands; sampled with start
//   busy  : high in RUN, while words are being processed
//   done  : one-cycle pulse; the result is valid
//   sum   : N-bit registered result
//   co    : final carry out of the MSW (for sub, 1 = no borrow)
//   ovf   : signed two's-complement overflow of the N-bit operation
// ---------------------------------------------------------------------------
module mp_add_seq #(
  parameter int WIDTH = 32,  // must stay 32 to match the cla_32bits instance
  parameter int WORDS = 4    // >= 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   co,
  output logic                   ovf
);

  localparam int N  = WIDTH * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;      // already inverted when subtracting
  logic [N-1:0]    r_sum;
  logic [IW-1:0]   r_idx;
  logic            r_carry;  // preset to sub on accept, so it also holds the +1 of a-b
  logic            r_co;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;

  logic [WIDTH-1:0] w_a_word;
  logic [WIDTH-1:0] w_b_word;
  logic [WIDTH-1:0] w_s;
  logic             w_co;
  logic             w_accept;

  assign w_a_word = r_a[r_idx*WIDTH +: WIDTH];
  assign w_b_word = r_b[r_idx*WIDTH +: WIDTH];
  assign w_accept = start && (r_state != RUN);

  cla_32bits u_cla (
    .a  (w_a_word),
    .b  (w_b_word),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b ^ {N{sub}};
            r_carry <= sub;
            r_idx   <= '0;
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          r_sum[r_idx*WIDTH +: WIDTH] <= w_s;
          r_carry <= w_co;
          if (r_idx == LAST_IDX) begin
            // Last word: publish the flags. w_s[WIDTH-1] is the result's MSB.
            r_co    <= w_co;
            r_ovf   <= (r_a[N-1] == r_b[N-1]) && (w_s[WIDTH-1] != r_a[N-1]);
            r_idx   <= '0;
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign co   = r_co;
  assign ovf  = r_ovf;

endmodule

// ---------------------------------------------------------------------------
// cla_32bits -- 32-bit carry-lookahead adder.
// It uses 4-bit lookahead groups. The group generate/propagate signals
// drive the group carry-in chain.
//
// Ports:
//   a, b : 32-bit addends
//   ci   : carry in
//   s    : 32-bit sum
//   co   : carry out
// ---------------------------------------------------------------------------
module cla_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [7:0] w_gg;  // group generate
  logic [7:0] w_gp;  // group propagate
  logic [8:0] w_gc;  // group carry-in chain

  always_comb begin
    w_gc[0] = ci;
    for (int i = 0; i < 8; i++) begin
      w_gc[i+1] = w_gg[i] | (w_gp[i] & w_gc[i]);
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
      localparam int L = gi * 4;
      logic [3:0] w_g;
      logic [3:0] w_p;
      logic       w_c0, w_c1, w_c2, w_c3;

      assign w_g  = a[L +: 4] & b[L +: 4];
      assign w_p  = a[L +: 4] ^ b[L +: 4];
      assign w_c0 = w_gc[gi];
      assign w_c1 = w_g[0] | (w_p[0] & w_c0);
      assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c0);
      assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c0);
      assign w_gg[gi] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                      | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
      assign w_gp[gi] = &w_p;
      assign s[L +: 4] = w_p ^ {w_c3, w_c2, w_c1, w_c0};
    end
  endgenerate

  assign co = w_gc[8];

endmodule

// File: tb/tb_mp_add_seq.sv
// ---------------------------------------------------------------------------
// tb_mp_add_seq -- directed self-checking bench for mp_add_seq (128-bit,
// 4 x 32-bit words). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mp_add_seq;

  localparam int N = 128;
  localparam logic [N-1:0] ONES = {N{1'b1}};
  localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         co;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;
  int bcnt;
  int done_seen;

  mp_add_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present an operation and take the accept edge.
  task automatic start_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic isub);
    a = ia; b = ib; sub = isub; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; counts edges since the accept edge and busy cycles.
  task automatic wait_done(input int cyc0, output int ocyc, output int obcnt);
    ocyc = cyc0; obcnt = 0;
    while (done !== 1'b1 && ocyc < 20) begin
      if (busy === 1'b1) obcnt++;
      tick();
      ocyc++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [N-1:0] es, input logic eco, input logic eovf);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_co"},  {127'd0, co},  {127'd0, eco});
    chk({tag, "_ovf"}, {127'd0, ovf}, {127'd0, eovf});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk_res("rst", 128'd0, 1'b0, 1'b0);

    // Full carry ripple through all words
    start_op(ONES, 128'd1, 1'b0);
    chk("ripple_busy0", {127'd0, busy}, 128'd1);
    wait_done(0, cyc, bcnt);
    chk("ripple_lat", cyc, 4);
    chk("ripple_busycnt", bcnt, 4);
    chk_res("ripple", 128'd0, 1'b1, 1'b0);
    tick();
    chk("idle_done", {127'd0, done}, 128'd0);
    chk("idle_busy", {127'd0, busy}, 128'd0);

    // Subtract with borrow: 0 - 1
    start_op(128'd0, 128'd1, 1'b1);
    wait_done(0, cyc, bcnt);
    chk("borrow_lat", cyc, 4);
    chk_res("borrow", ONES, 1'b0, 1'b0);
    tick();

    // 5 - 3
    start_op(128'd5, 128'd3, 1'b1);
    wait_done(0, cyc, bcnt);
    chk_res("sub53", 128'd2, 1'b1, 1'b0);
    tick();

    // Positive overflow: MAX + 1
    start_op(MAXP, 128'd1, 1'b0);
    wait_done(0, cyc, bcnt);
    chk_res("ovf_add", MINN, 1'b0, 1'b1);
    tick();

    // Negative overflow: MIN - 1
    start_op(MINN, 128'd1, 1'b1);
    wait_done(0, cyc, bcnt);
    chk_res("ovf_sub", MAXP, 1'b1, 1'b1);
    tick();

    // Busy-ignore: re-pulse start with new operands mid-RUN
    start_op(128'h0123_4567_89AB_CDEF_FFFF_FFFF_0000_0001,
             128'h1111_1111_1111_1111_0000_0001_FFFF_FFFF, 1'b0);
    tick();
    a = ONES; b = ONES; sub = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0;
    wait_done(2, cyc, bcnt);
    chk("ignore_lat", cyc, 4);
    chk_res("ignore", 128'h1234_5678_9ABC_DF01_0000_0001_0000_0000, 1'b0, 1'b0);

    // Back-to-back: start while in DONE
    start_op(128'd100, 128'd58, 1'b0);
    chk("b2b_busy", {127'd0, busy}, 128'd1);
    chk("b2b_done", {127'd0, done}, 128'd0);
    wait_done(0, cyc, bcnt);
    chk("b2b_lat", cyc, 4);
    chk_res("b2b", 128'd158, 1'b0, 1'b0);
    tick();

    // Reset after two words, then no done pulse
    start_op(ONES, 128'd1, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", {127'd0, busy}, 128'd0);
    chk("mrst_done", {127'd0, done}, 128'd0);
    chk_res("mrst", 128'd0, 1'b0, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    chk("mrst_nodone", done_seen, 0);

    // Recovery after reset
    start_op(128'd5, 128'd3, 1'b1);
    wait_done(0, cyc, bcnt);
    chk("recover_lat", cyc, 4);
    chk_res("recover", 128'd2, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 Parameter: WIDTH, 32, adder word width; SHALL match the cla_32bits instance width.
REQ-002 Parameter: WORDS, 4, number of words per operand; SHALL be >= 2 (operand width N = WIDTH*WORDS).
REQ-003 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request pulse; sampled only when busy=0.
REQ-006 Port: sub  input  1  operation select: 0 = a+b, 1 = a-b; sampled with start.
REQ-007 Port: a  input  N  first operand; sampled with start.
REQ-008 Port: b  input  N  second operand; sampled with start.
REQ-009 Port: busy  output  1  high while words are being processed.
REQ-010 Port: done  output  1  one-cycle pulse; result valid.
REQ-011 Port: sum  output  N  result, registered.
REQ-012 Port: co  output  1  final carry out of the MSW; for sub, 1 = no borrow.
REQ-013 Port: ovf  output  1  signed two's-complement overflow of the N-bit operation.

Function
REQ-014 The block SHALL contain exactly one cla_32bits instance (ports a, b, ci, s, co) and SHALL use it for every word addition; no other N-bit or WIDTH-bit adder on the datapath.
REQ-015 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-016 Transition IDLE->RUN on start=1; DONE->RUN on start=1; DONE->IDLE on start=0; RUN->DONE after the last word; there are no other transitions.
REQ-017 Accept (start=1 in IDLE or DONE): latch a, latch b XOR {N{sub}}, latch sub; load carry register with sub; clear word index to 0.
REQ-018 RUN, each cycle: adder inputs = latched word[idx] of a and b, ci = carry register; on the edge, write s into sum word idx, load co into the carry register, and increment idx.
REQ-019 The RUN state SHALL last exactly WORDS cycles, with the LSW first; the edge that processes word WORDS-1 SHALL enter DONE.
REQ-020 Latency: start sampled at edge E0 -> done=1 in the cycle following edge E(WORDS); for WORDS=4, done is high 4 cycles after the start edge.
REQ-021 Output co SHALL be the carry register after the last word; ovf SHALL equal (a_msb==b'_msb) && (sum_msb!=a_msb), where b' is the latched, possibly inverted b.
REQ-022 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-023 start while busy=1 SHALL be ignored: no re-latch and no effect on the result.
REQ-024 Input changes on a, b, sub after the accept edge SHALL NOT affect the current result.
REQ-025 sum, co, ovf SHALL hold the last completed result from DONE until the next accept; during RUN, sum words SHALL update progressively, and co/ovf SHALL update only on entry to DONE.
REQ-026 Back-to-back: start=1 during DONE SHALL begin the next operation with no idle cycle.
REQ-027 The word index SHALL use ceil(log2(WORDS)) bits (minimum 1) and SHALL NOT be used to address beyond WORDS-1.

Reset
REQ-028 When rst=1 at an edge, in any state (including mid-RUN), the block SHALL go to IDLE and clear busy, done, sum, co, ovf, the carry register, the index, and the latched operands to 0.
REQ-029 rst SHALL take priority over start on the same edge.
REQ-030 After a mid-operation reset, the block SHALL NOT produce a done pulse for the aborted operation.

Verification
REQ-031 Reset: hold rst for 2 cycles -> busy=0, done=0, sum=0, co=0, ovf=0.
REQ-032 Full carry ripple: a=all-ones (128b), b=1, sub=0 -> sum=0, co=1, ovf=0; done exactly 4 cycles after the start edge, busy high for 4 cycles.
REQ-033 Subtract with borrow: a=0, b=1, sub=1 -> sum=all-ones, co=0, ovf=0; then a=5, b=3, sub=1 -> sum=2, co=1.
REQ-034 Signed overflow: a=0x7FFF...F, b=1, sub=0 -> sum=0x8000...0, ovf=1, co=0; a=0x8000...0, b=1, sub=1 -> ovf=1.
REQ-035 Busy-ignore and back-to-back: pulse start and change a/b mid-RUN -> the result matches the originally sampled operands; start in DONE -> busy=1 on the next cycle, and the second result is correct.
REQ-036 Reset mid-RUN after 2 words -> IDLE next cycle, all outputs 0, no done; the next start completes normally.
